// File: rtl/breakout_ctrl_if.sv
// Game-flow bus between the breakout controller and its keypad/graph/display neighbours.
// Carries level inputs (keypad, hit, miss) and registered controller outputs; no handshake or backpressure.
interface breakout_ctrl_if;
  logic        key_ready;
  logic [4:0]  key_code;
  logic        hit;
  logic        miss;
  logic [1:0]  state;
  logic        gra_still;
  logic        launch;
  logic [1:0]  lives;
  logic [15:0] score_bcd;
  logic [31:0] seg_data;

  modport master (
    output key_ready, key_code, hit, miss,
    input  state, gra_still, launch, lives, score_bcd, seg_data
  );

  modport slave (
    input  key_ready, key_code, hit, miss,
    output state, gra_still, launch, lives, score_bcd, seg_data
  );
endinterface

// File: rtl/breakout_ctrl.sv
// Breakout game-flow FSM (NEWGAME/PLAY/NEWBALL/OVER) with saturating BCD score and high score.
// Input edges act on the next clock edge, all outputs registered; no backpressure, inputs are edge-detected levels.
module breakout_ctrl #(
  parameter int         LIVES     = 3,
  parameter int         DELAY     = 100_000_000,
  parameter logic [4:0] START_KEY = 5'h12
) (
  input  logic          clk,
  input  logic          rstn,
  breakout_ctrl_if.slave bus
);

  localparam int TW = $clog2(DELAY + 1);

  typedef enum logic [1:0] {
    NEWGAME = 2'b00,
    PLAY    = 2'b01,
    NEWBALL = 2'b10,
    OVER    = 2'b11
  } state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [1:0]    lives_q, lives_d;
  logic [15:0]   score_q, score_d;
  logic [15:0]   high_q, high_d;
  logic [15:0]   score_inc;
  logic          launch_q, launch_d;
  logic          key_q, hit_q, miss_q;
  logic          start_ev, hit_ev, miss_ev;

  // Per-digit BCD increment that sticks at 9999 instead of wrapping.
  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        carry;
    r     = v;
    carry = 1'b1;
    if (v != 16'h9999) begin
      for (int i = 0; i < 4; i++) begin
        if (carry) begin
          if (r[i*4 +: 4] == 4'd9) begin
            r[i*4 +: 4] = 4'd0;
          end else begin
            r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
            carry       = 1'b0;
          end
        end
      end
    end
    return r;
  endfunction

  assign start_ev = bus.key_ready & ~key_q & (bus.key_code == START_KEY);
  assign hit_ev   = bus.hit  & ~hit_q;
  assign miss_ev  = bus.miss & ~miss_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      key_q  <= 1'b0;
      hit_q  <= 1'b0;
      miss_q <= 1'b0;
    end else begin
      key_q  <= bus.key_ready;
      hit_q  <= bus.hit;
      miss_q <= bus.miss;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= NEWGAME;
      timer_q  <= '0;
      lives_q  <= 2'(LIVES);
      score_q  <= '0;
      high_q   <= '0;
      launch_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      lives_q  <= lives_d;
      score_q  <= score_d;
      high_q   <= high_d;
      launch_q <= launch_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    lives_d   = lives_q;
    score_d   = score_q;
    high_d    = high_q;
    score_inc = hit_ev ? bcd_inc(score_q) : score_q;
    timer_d   = (timer_q != '0) ? timer_q - TW'(1) : timer_q;

    unique case (state_q)
      NEWGAME: begin
        if (start_ev) begin
          score_d = '0;
          lives_d = 2'(LIVES);
          state_d = PLAY;
        end
      end
      PLAY: begin
        // Score update lands first so a same-cycle miss sees the incremented value.
        score_d = score_inc;
        if (miss_ev) begin
          timer_d = TW'(DELAY);
          if (lives_q > 2'd1) begin
            lives_d = lives_q - 2'd1;
            state_d = NEWBALL;
          end else begin
            lives_d = 2'd0;
            state_d = OVER;
            if (score_inc > high_q) high_d = score_inc;
          end
        end
      end
      NEWBALL: begin
        if (start_ev && timer_q == '0) state_d = PLAY;
      end
      OVER: begin
        if (start_ev && timer_q == '0) state_d = NEWGAME;
      end
      default: state_d = NEWGAME;
    endcase

    launch_d = (state_d == PLAY) && (state_q != PLAY);
  end

  assign bus.state     = state_q;
  assign bus.gra_still = (state_q != PLAY);
  assign bus.launch    = launch_q;
  assign bus.lives     = lives_q;
  assign bus.score_bcd = score_q;
  assign bus.seg_data  = {high_q, score_q};

endmodule

// File: tb/tb_breakout_ctrl.sv
// Randomized bench for breakout_ctrl against a game-rule reference model (decimal score, named states).
module tb_breakout_ctrl;
  localparam int         DELAY = 8;
  localparam int         LIVES = 3;
  localparam logic [4:0] START = 5'h12;
  localparam int S_NEWGAME = 0, S_PLAY = 1, S_NEWBALL = 2, S_OVER = 3;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  breakout_ctrl_if bif ();

  breakout_ctrl #(.LIVES(LIVES), .DELAY(DELAY), .START_KEY(START)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bif.slave)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int launch_cnt = 0;
  int m_state, m_score, m_high, m_lives;

  always @(negedge clk) if (bif.launch === 1'b1) launch_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic model_reset();
    m_state = S_NEWGAME; m_score = 0; m_high = 0; m_lives = LIVES;
  endtask

  // Callers only press start in NEWBALL/OVER once the countdown has fully elapsed.
  task automatic model_start();
    case (m_state)
      S_NEWGAME: begin m_score = 0; m_lives = LIVES; m_state = S_PLAY; end
      S_NEWBALL: m_state = S_PLAY;
      S_OVER:    m_state = S_NEWGAME;
      default: ;
    endcase
  endtask

  task automatic model_hit();
    if (m_state == S_PLAY && m_score < 9999) m_score++;
  endtask

  task automatic model_miss();
    if (m_state == S_PLAY) begin
      if (m_lives > 1) begin
        m_lives--; m_state = S_NEWBALL;
      end else begin
        m_lives = 0; m_state = S_OVER;
        if (m_score > m_high) m_high = m_score;
      end
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, "_state"}, 32'(bif.state), 32'(m_state));
    check({tag, "_lives"}, 32'(bif.lives), 32'(m_lives));
    check({tag, "_score"}, 32'(bif.score_bcd), 32'(to_bcd(m_score)));
    check({tag, "_seg"}, bif.seg_data, {to_bcd(m_high), to_bcd(m_score)});
    check({tag, "_still"}, 32'(bif.gra_still), 32'(m_state != S_PLAY));
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic [4:0] code);
    bif.key_code = code; bif.key_ready = 1'b1;
    tick(2);
    bif.key_ready = 1'b0;
    tick(2);
  endtask

  task automatic hit_pulse(input int w);
    bif.hit = 1'b1; tick(w); bif.hit = 1'b0; tick(1);
    model_hit();
  endtask

  task automatic miss_pulse();
    bif.miss = 1'b1; tick(1); bif.miss = 1'b0; tick(1);
    model_miss();
  endtask

  task automatic hit_and_miss();
    bif.hit = 1'b1; bif.miss = 1'b1; tick(1);
    bif.hit = 1'b0; bif.miss = 1'b0; tick(1);
    model_hit(); model_miss();
  endtask

  task automatic start_after_wait();
    tick(DELAY + 2);
    press(START);
    model_start();
  endtask

  task automatic end_game();
    for (int i = 0; i < 8 && m_state != S_NEWGAME; i++) begin
      if (m_state == S_PLAY) miss_pulse();
      start_after_wait();
    end
  endtask

  initial begin
    int l0, n;
    logic [4:0] code;
    bif.key_ready = 1'b0; bif.key_code = 5'h0; bif.hit = 1'b1; bif.miss = 1'b0;
    model_reset();

    // Reset, with hit held high through the release.
    tick(2);
    rstn = 1'b1;
    tick(3);
    check_all("reset");
    check("reset_launch", 32'(launch_cnt), 32'd0);
    bif.hit = 1'b0;
    tick(2);

    // Start and ten 3-cycle hits.
    l0 = launch_cnt;
    press(START); model_start();
    check("start_launch", 32'(launch_cnt - l0), 32'd1);
    check_all("start");
    for (int i = 0; i < 10; i++) hit_pulse(3);
    check("score10", 32'(bif.score_bcd), 32'h0010);
    check_all("score10");

    // Miss with lives left; early start is dropped, late start resumes.
    miss_pulse();
    check("miss_state", 32'(bif.state), 32'd2);
    check("miss_lives", 32'(bif.lives), 32'd2);
    tick(2);
    press(START);
    check("early_start", 32'(bif.state), 32'd2);
    l0 = launch_cnt;
    start_after_wait();
    check("resume_launch", 32'(launch_cnt - l0), 32'd1);
    check_all("resume");

    // Reach 25 on the last ball, then a simultaneous hit and miss.
    for (int i = 0; i < 15; i++) hit_pulse(1);
    miss_pulse();
    start_after_wait();
    check_all("last_ball");
    hit_and_miss();
    check("over_seg", bif.seg_data, 32'h00260026);
    check_all("over");
    start_after_wait();
    check("over_to_newgame_seg", bif.seg_data, 32'h00260026);
    check_all("newgame");

    // Random games: hits of random width, stray keys, hits/misses outside PLAY.
    for (int r = 0; r < 12; r++) begin
      if (m_state == S_NEWGAME) begin press(START); model_start(); end
      n = $urandom_range(0, 15);
      for (int k = 0; k < n; k++) begin
        if ($urandom_range(0, 3) == 0) begin
          code = 5'($urandom_range(0, 31));
          if (code == START) code = 5'h10;
          press(code);
        end else begin
          hit_pulse($urandom_range(1, 4));
        end
      end
      check_all("rnd_play");
      if ($urandom_range(0, 1) == 1) hit_and_miss(); else miss_pulse();
      check_all("rnd_miss");
      if ($urandom_range(0, 1) == 1) press(START);
      if ($urandom_range(0, 1) == 1) hit_pulse(1);
      if ($urandom_range(0, 1) == 1) miss_pulse();
      check_all("rnd_wait");
      start_after_wait();
      check_all("rnd_resume");
    end
    end_game();
    check_all("rnd_end");

    // Saturation at 9999.
    press(START); model_start();
    for (int i = 0; i < 9998; i++) hit_pulse(1);
    check("pre_sat", 32'(bif.score_bcd), 32'h9998);
    for (int i = 0; i < 3; i++) hit_pulse(1);
    check("sat", 32'(bif.score_bcd), 32'h9999);
    check_all("sat");
    end_game();
    check_all("sat_over");
    l0 = launch_cnt;
    press(5'h10);
    check("wrong_key_state", 32'(bif.state), 32'd0);
    check("wrong_key_launch", 32'(launch_cnt - l0), 32'd0);

    // Reset in the middle of a NEWBALL countdown.
    press(START); model_start();
    miss_pulse();
    check("pre_rst_state", 32'(bif.state), 32'd2);
    tick(2);
    rstn = 1'b0;
    #1;
    model_reset();
    check("rst_state", 32'(bif.state), 32'd0);
    check("rst_lives", 32'(bif.lives), 32'd3);
    check("rst_score", 32'(bif.score_bcd), 32'd0);
    check("rst_seg", bif.seg_data, 32'd0);
    tick(2);
    rstn = 1'b1;
    tick(DELAY + 2);
    check_all("post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
